led_fader: RTL and testbench

// - Downstream stage of the LED blinker. Consumes its on/off `led` level on led_in and drives the physical LED pin.
// - Drives the pin with PWM whose brightness ramps smoothly up and down instead of switching hard.
// - Brightness cap comes from max_level. Busy status is exported for a status register.

---
 rtl/led_fader.sv | 97 +++++++++
 tb/tb_led_fader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// PWM LED driver that ramps brightness toward led_in ? max_level : 0 one level per fade step.
// Define LED_FADER_GAMMA_EN to map level to duty through a squared (gamma) curve.
module led_fader #(
   parameter int CLK_FREQ_KHz = 50000,
   parameter int PWM_FREQ_Hz  = 1000,
   parameter int PWM_BITS     = 8,
   parameter int FADE_DIV     = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                led_in,
   input  logic [PWM_BITS-1:0] max_level,
   output logic                pwm_out,
   output logic [PWM_BITS-1:0] level,
   output logic                busy
);

   localparam int TICK_DIV = (CLK_FREQ_KHz * 1000) / (PWM_FREQ_Hz * (2 ** PWM_BITS));
   localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int FW       = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [FW-1:0] FADE_LAST = FW'(FADE_DIV - 1);

   if (TICK_DIV < 1) begin : g_bad_tick
      $error("led_fader: TICK_DIV < 1, clock too slow for PWM_FREQ_Hz/PWM_BITS");
   end
   if (FADE_DIV < 1) begin : g_bad_fade
      $error("led_fader: FADE_DIV must be >= 1");
   end

   typedef enum logic [1:0] {OFF, RISE, ON, FALL} state_t;

   state_t              state, nxt;
   logic                led_q;
   logic [PWM_BITS-1:0] max_q, target, duty_q, duty_nxt, pwm_cnt;
   logic [TW-1:0]       tick_cnt;
   logic [FW-1:0]       fade_cnt;
   logic                tick, pb, step;

   always_comb begin
      target = led_q ? max_q : '0;
      tick   = (tick_cnt == TICK_LAST);
      pb     = tick && (&pwm_cnt);
      step   = pb && (fade_cnt == FADE_LAST);
      if (level < target)      nxt = RISE;
      else if (level > target) nxt = FALL;
      else if (level != '0)    nxt = ON;
      else                     nxt = OFF;
   end

`ifdef LED_FADER_GAMMA_EN
   logic [2*PWM_BITS-1:0] sq;
   always_comb begin
      sq       = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
      // full scale must stay full scale; the square alone would top out one short
      duty_nxt = (&level) ? '1 : sq[2*PWM_BITS-1:PWM_BITS];
   end
`else
   assign duty_nxt = level;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= OFF;
         busy     <= 1'b0;
         level    <= '0;
         pwm_out  <= 1'b0;
         led_q    <= 1'b0;
         max_q    <= '0;
         duty_q   <= '0;
         pwm_cnt  <= '0;
         tick_cnt <= '0;
         fade_cnt <= '0;
      end else begin
         led_q    <= led_in;
         max_q    <= max_level;
         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
         if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         // duty only changes at the period boundary so a period is never cut short
         if (pb) duty_q <= duty_nxt;
         pwm_out <= (pwm_cnt < duty_q);

         if (nxt == OFF || nxt == ON) fade_cnt <= '0;
         else if (pb)                 fade_cnt <= (fade_cnt == FADE_LAST) ? '0 : fade_cnt + FW'(1);

         // the target compare guards against stepping past a target that just moved
         if (step) begin
            if (state == RISE && level < target)      level <= level + PWM_BITS'(1);
            else if (state == FALL && level > target) level <= level - PWM_BITS'(1);
         end

         state <= nxt;
         busy  <= (nxt == RISE) || (nxt == FALL);
      end
   end

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: randomized and directed stimulus against a cycle-count based model.
module tb_led_fader;
   localparam int PB = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          led_in = 1'b0;
   logic [PB-1:0] max_level = '0;
   logic          pwm_out;
   logic [PB-1:0] level;
   logic          busy;

   int checks = 0;
   int failures = 0;

   // model: cycles since reset, level, loaded duty, targets seen one and two cycles back
   int m_n, m_lvl, m_duty, m_t1, m_t2;
   logic m_pwm, m_busy;

   led_fader #(.CLK_FREQ_KHz(1), .PWM_FREQ_Hz(31), .PWM_BITS(PB), .FADE_DIV(1)) dut (
      .clk(clk), .rst(rst), .led_in(led_in), .max_level(max_level),
      .pwm_out(pwm_out), .level(level), .busy(busy));

   always #5 clk = ~clk;

   function automatic int dutyf(input int l);
`ifdef LED_FADER_GAMMA_EN
      return (l == 15) ? 15 : (l * l) >> 4;
`else
      return l;
`endif
   endfunction

   // Advance one clock and move the model with it. Tick every 2nd cycle, so a PWM
   // period is 32 cycles and the boundary falls on the last cycle of each period.
   // A level step needs the target to agree over the two cycles the decision spans.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (!rst) begin
         m_n = 0; m_lvl = 0; m_duty = 0; m_t1 = 0; m_t2 = 0;
         m_pwm = 1'b0; m_busy = 1'b0;
      end else begin
         m_pwm  = (((m_n / 2) % 16) < m_duty);
         m_busy = (m_lvl != m_t1);
         if (m_n % 32 == 31) begin
            m_duty = dutyf(m_lvl);
            if (m_lvl < m_t1 && m_lvl < m_t2)      m_lvl++;
            else if (m_lvl > m_t1 && m_lvl > m_t2) m_lvl--;
         end
         m_t2 = m_t1;
         m_t1 = led_in ? int'(max_level) : 0;
         m_n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; led_in = 1'b1; max_level = 4'd15;
      repeat (3) begin
         cyc();
         checks++;
         if ({pwm_out, busy, level} !== 6'b0) begin
            failures++;
            $display("FAIL reset: got pwm=%0b busy=%0b level=%0d, want all 0", pwm_out, busy, level);
         end
      end
      led_in = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_rise();
      int hi = 0;
      bit done = 0;
      led_in = 1'b1; max_level = 4'd15;
      for (int i = 0; i < 700 && !done; i++) begin
         cyc();
         checks++;
         if ({pwm_out, busy, level} !== {m_pwm, m_busy, 4'(m_lvl)}) begin
            failures++;
            $display("FAIL rise: got pwm=%0b busy=%0b level=%0d, want %0b %0b %0d", pwm_out, busy, level, m_pwm, m_busy, m_lvl);
         end
         done = (m_lvl == 15 && !m_busy);
      end
      checks++;
      if (!done) begin failures++; $display("FAIL rise_timeout: level=%0d busy=%0b, want 15 0", level, busy); end
      repeat (40) cyc();
      for (int i = 0; i < 32; i++) begin cyc(); hi += int'(pwm_out); end
      checks++;
      if (hi != 2 * dutyf(15)) begin
         failures++;
         $display("FAIL rise_duty: got %0d high cycles, want %0d", hi, 2 * dutyf(15));
      end
   endtask

   task automatic test_fall();
      int hi = 0;
      bit done = 0;
      led_in = 1'b0;
      for (int i = 0; i < 700 && !done; i++) begin
         cyc();
         checks++;
         if ({pwm_out, busy, level} !== {m_pwm, m_busy, 4'(m_lvl)}) begin
            failures++;
            $display("FAIL fall: got pwm=%0b busy=%0b level=%0d, want %0b %0b %0d", pwm_out, busy, level, m_pwm, m_busy, m_lvl);
         end
         done = (m_lvl == 0 && !m_busy);
      end
      checks++;
      if (!done) begin failures++; $display("FAIL fall_timeout: level=%0d busy=%0b, want 0 0", level, busy); end
      repeat (34) cyc();
      for (int i = 0; i < 32; i++) begin cyc(); hi += int'(pwm_out); end
      checks++;
      if (hi != 0) begin failures++; $display("FAIL fall_dark: got %0d high cycles, want 0", hi); end
   endtask

   task automatic test_reversal();
      int peak = 0;
      bit done = 0;
      led_in = 1'b1; max_level = 4'd15;
      for (int i = 0; i < 400 && m_lvl != 7; i++) cyc();
      led_in = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         cyc();
         if (int'(level) > peak) peak = int'(level);
         checks++;
         if ({pwm_out, busy, level} !== {m_pwm, m_busy, 4'(m_lvl)}) begin
            failures++;
            $display("FAIL reversal: got pwm=%0b busy=%0b level=%0d, want %0b %0b %0d", pwm_out, busy, level, m_pwm, m_busy, m_lvl);
         end
         done = (m_lvl == 0 && !m_busy);
      end
      checks++;
      if (!done || peak != 7) begin
         failures++;
         $display("FAIL reversal_peak: got peak=%0d done=%0b, want 7 1", peak, done);
      end
   endtask

   task automatic test_cap_change();
      int hi = 0;
      bit done = 0;
      led_in = 1'b1; max_level = 4'd15;
      for (int i = 0; i < 700 && !(m_lvl == 15 && !m_busy); i++) cyc();
      max_level = 4'd5;
      for (int i = 0; i < 500 && !done; i++) begin
         cyc();
         checks++;
         if ({pwm_out, busy, level} !== {m_pwm, m_busy, 4'(m_lvl)}) begin
            failures++;
            $display("FAIL cap: got pwm=%0b busy=%0b level=%0d, want %0b %0b %0d", pwm_out, busy, level, m_pwm, m_busy, m_lvl);
         end
         done = (m_lvl == 5 && !m_busy);
      end
      repeat (40) cyc();
      for (int i = 0; i < 32; i++) begin cyc(); hi += int'(pwm_out); end
      checks++;
      if (!done || level !== 4'd5 || hi != 2 * dutyf(5)) begin
         failures++;
         $display("FAIL cap_duty: got level=%0d high=%0d, want 5 %0d", level, hi, 2 * dutyf(5));
      end
   endtask

   task automatic test_mid_reset();
      int hi = 0;
      led_in = 1'b1; max_level = 4'd15;
      for (int i = 0; i < 500 && m_lvl != 9; i++) cyc();
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      checks++;
      if ({pwm_out, busy, level} !== 6'b0) begin
         failures++;
         $display("FAIL mid_reset: got pwm=%0b busy=%0b level=%0d, want all 0", pwm_out, busy, level);
      end
      max_level = 4'd8;
      for (int i = 0; i < 400; i++) begin
         cyc();
         checks++;
         if ({pwm_out, busy, level} !== {m_pwm, m_busy, 4'(m_lvl)}) begin
            failures++;
            $display("FAIL restart: got pwm=%0b busy=%0b level=%0d, want %0b %0b %0d", pwm_out, busy, level, m_pwm, m_busy, m_lvl);
         end
      end
      for (int i = 0; i < 32; i++) begin cyc(); hi += int'(pwm_out); end
      checks++;
      if (level !== 4'd8 || hi != 2 * dutyf(8)) begin
         failures++;
         $display("FAIL duty8: got level=%0d high=%0d, want 8 %0d", level, hi, 2 * dutyf(8));
      end
   endtask

   task automatic test_random();
      for (int seg = 0; seg < 20; seg++) begin
         led_in    = 1'($urandom_range(0, 1));
         max_level = 4'($urandom_range(0, 15));
         if (seg % 5 == 4) max_level = '0;
         for (int i = 0, n = $urandom_range(3, 300); i < n; i++) begin
            cyc();
            checks++;
            if ({pwm_out, busy, level} !== {m_pwm, m_busy, 4'(m_lvl)}) begin
               failures++;
               $display("FAIL random: got pwm=%0b busy=%0b level=%0d, want %0b %0b %0d", pwm_out, busy, level, m_pwm, m_busy, m_lvl);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_fall();
      test_reversal();
      test_cap_change();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
